// File: rtl/uart_frame_rx.sv
// UART receiver (8N1, LSB first) with command-frame assembly.
// Good bytes are packed into a FRAME_BYTES-wide frame, opcode byte first.
// A framing error or an idle timeout throws away a partial frame.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 2,
  parameter int FRAME_BYTES  = 7,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Rx_Serial,
  output logic                     o_Rx_DV,
  output logic [7:0]               o_Rx_Byte,
  output logic                     o_Frame_Valid,
  output logic [8*FRAME_BYTES-1:0] o_Frame,
  output logic                     o_Frame_Err,
  output logic                     o_Busy
);

  localparam int FRAME_W  = 8 * FRAME_BYTES;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int TMO_W    = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [FRAME_W-1:0]   buf_q, buf_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [7:0]           rx_byte_q, rx_byte_d;
  logic                 rx_dv_q, rx_dv_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [FRAME_W-1:0]   completed_frame;

  // Register all state; synchronizer presets to the idle-high line level.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q       <= S_IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_idx_q    <= '0;
      tmo_cnt_q     <= '0;
      buf_q         <= '0;
      frame_q       <= '0;
      rx_byte_q     <= '0;
      rx_dv_q       <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      byte_idx_q    <= byte_idx_d;
      tmo_cnt_q     <= tmo_cnt_d;
      buf_q         <= buf_d;
      frame_q       <= frame_d;
      rx_byte_q     <= rx_byte_d;
      rx_dv_q       <= rx_dv_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Bit-level FSM, frame slot writes and partial-frame timeout.
  always_comb begin
    state_d       = state_q;
    rx_meta_d     = i_Rx_Serial;
    rx_s_d        = rx_meta_q;
    clk_cnt_d     = clk_cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    byte_idx_d    = byte_idx_q;
    tmo_cnt_d     = tmo_cnt_q;
    buf_d         = buf_q;
    frame_d       = frame_q;
    rx_byte_d     = rx_byte_q;
    rx_dv_d       = 1'b0;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    // The assembly buffer with the just-shifted byte dropped into its slot.
    completed_frame = buf_q;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (byte_idx_q == IDX_W'(i)) begin
        completed_frame[FRAME_W-8-8*i +: 8] = shift_q;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (byte_idx_q != '0) begin
          if (tmo_cnt_q == TMO_LAST) begin
            byte_idx_d  = '0;
            tmo_cnt_d   = '0;
            frame_err_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end else begin
          tmo_cnt_d = '0;
        end
        // A start bit coinciding with expiry still starts a byte, but the
        // index was already cleared above so it becomes byte 0.
        if (!rx_s_q) begin
          state_d   = S_START;
          clk_cnt_d = '0;
          tmo_cnt_d = '0;
        end
      end

      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            rx_dv_d   = 1'b1;
            rx_byte_d = shift_q;
            buf_d     = completed_frame;
            state_d   = S_IDLE;
            if (byte_idx_q == IDX_LAST) begin
              frame_d       = completed_frame;
              frame_valid_d = 1'b1;
              byte_idx_d    = '0;
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end else begin
            frame_err_d = (byte_idx_q != '0) || (FRAME_BYTES == 1);
            byte_idx_d  = '0;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_Rx_DV       = rx_dv_q;
  assign o_Rx_Byte     = rx_byte_q;
  assign o_Frame_Valid = frame_valid_q;
  assign o_Frame       = frame_q;
  assign o_Frame_Err   = frame_err_q;
  assign o_Busy        = (state_q != S_IDLE) || (byte_idx_q != '0);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: drives 8N1 serial bytes and checks
// received bytes, frames, error strobes, busy and latency.
module tb_uart_frame_rx;

  localparam int CPB = 2;
  localparam int NB  = 7;
  localparam int TMO = 1024;

  logic          i_Clock = 1'b0;
  logic          i_Reset;
  logic          i_Rx_Serial;
  logic          o_Rx_DV;
  logic [7:0]    o_Rx_Byte;
  logic          o_Frame_Valid;
  logic [8*NB-1:0] o_Frame;
  logic          o_Frame_Err;
  logic          o_Busy;

  int n_vec  = 0;
  int n_fail = 0;
  int cycle  = 0;
  int err_cnt = 0;
  int last_err_cycle = 0;
  logic [7:0]  rx_q[$];
  int          dv_cyc_q[$];
  logic [55:0] frame_q[$];

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .FRAME_BYTES (NB),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_Rx_Serial  (i_Rx_Serial),
    .o_Rx_DV      (o_Rx_DV),
    .o_Rx_Byte    (o_Rx_Byte),
    .o_Frame_Valid(o_Frame_Valid),
    .o_Frame      (o_Frame),
    .o_Frame_Err  (o_Frame_Err),
    .o_Busy       (o_Busy)
  );

  // 10 ns system clock.
  always #5 i_Clock = ~i_Clock;

  // Free-running cycle count used for latency measurements.
  always @(posedge i_Clock) cycle <= cycle + 1;

  // Record every strobe on the falling edge, away from the active edge.
  always @(negedge i_Clock) begin
    if (o_Rx_DV) begin
      rx_q.push_back(o_Rx_Byte);
      dv_cyc_q.push_back(cycle);
    end
    if (o_Frame_Valid) frame_q.push_back(o_Frame);
    if (o_Frame_Err) begin
      err_cnt++;
      last_err_cycle = cycle;
    end
  end

  // Hard stop in case the run never reaches its summary line.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  // One 8N1 character; the line is left at the stop-bit level.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    i_Rx_Serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_Rx_Serial = b[i];
      tick(CPB);
    end
    i_Rx_Serial = stop_bit;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [55:0] f, input int gap);
    for (int k = 0; k < NB; k++) begin
      send_byte(f[55-8*k -: 8], 1'b1);
      if (gap > 0) tick(gap);
    end
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    i_Rx_Serial = 1'b1;
    tick(3);
    n_vec++; if (o_Rx_DV !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rx_dv: got %b expected 0", o_Rx_DV); end
    n_vec++; if (o_Rx_Byte !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rx_byte: got %h expected 00", o_Rx_Byte); end
    n_vec++; if (o_Frame !== 56'h0) begin n_fail++; $display("[TB] FAIL reset_frame: got %h expected 0", o_Frame); end
    n_vec++; if (o_Frame_Valid !== 1'b0 || o_Frame_Err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobes: got valid=%b err=%b expected 0 0", o_Frame_Valid, o_Frame_Err); end
    n_vec++; if (o_Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", o_Busy); end
    i_Reset = 1'b0;
    tick(5);
    n_vec++; if (o_Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_busy: got %b expected 0", o_Busy); end
  endtask

  task automatic test_nominal();
    logic [55:0] f;
    int rb, fb, eb, fall_cyc, lat;
    f  = 56'h01000000000010;
    rb = rx_q.size(); fb = frame_q.size(); eb = err_cnt;
    fall_cyc = cycle;
    send_frame(f, 40);
    tick(5);
    n_vec++;
    if (rx_q.size() - rb != NB) begin
      n_fail++; $display("[TB] FAIL nominal_dv_count: got %0d expected %0d", rx_q.size() - rb, NB);
    end else begin
      lat = dv_cyc_q[rb] - fall_cyc;
      n_vec++; if (lat < 20 || lat > 22) begin n_fail++; $display("[TB] FAIL nominal_latency: got %0d expected 20..22", lat); end
      for (int k = 0; k < NB; k++) begin
        n_vec++;
        if (rx_q[rb+k] !== f[55-8*k -: 8]) begin n_fail++; $display("[TB] FAIL nominal_byte%0d: got %h expected %h", k, rx_q[rb+k], f[55-8*k -: 8]); end
      end
    end
    n_vec++;
    if (frame_q.size() - fb != 1) begin
      n_fail++; $display("[TB] FAIL nominal_frame_count: got %0d expected 1", frame_q.size() - fb);
    end else begin
      n_vec++; if (frame_q[fb] !== f) begin n_fail++; $display("[TB] FAIL nominal_frame: got %h expected %h", frame_q[fb], f); end
    end
    n_vec++; if (err_cnt != eb) begin n_fail++; $display("[TB] FAIL nominal_err: got %0d expected 0", err_cnt - eb); end
    n_vec++; if (o_Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL nominal_busy: got %b expected 0", o_Busy); end
  endtask

  task automatic test_back_to_back();
    int fb, eb;
    fb = frame_q.size(); eb = err_cnt;
    send_frame(56'hA5A6A7A8A9AAAB, 0);
    send_frame(56'h11121314151617, 0);
    tick(20);
    n_vec++;
    if (frame_q.size() - fb != 2) begin
      n_fail++; $display("[TB] FAIL b2b_frame_count: got %0d expected 2", frame_q.size() - fb);
    end else begin
      n_vec++; if (frame_q[fb] !== 56'hA5A6A7A8A9AAAB) begin n_fail++; $display("[TB] FAIL b2b_frame0: got %h expected a5a6a7a8a9aaab", frame_q[fb]); end
      n_vec++; if (frame_q[fb+1] !== 56'h11121314151617) begin n_fail++; $display("[TB] FAIL b2b_frame1: got %h expected 11121314151617", frame_q[fb+1]); end
    end
    n_vec++; if (o_Frame !== 56'h11121314151617) begin n_fail++; $display("[TB] FAIL b2b_hold: got %h expected 11121314151617", o_Frame); end
    n_vec++; if (err_cnt != eb) begin n_fail++; $display("[TB] FAIL b2b_err: got %0d expected 0", err_cnt - eb); end
  endtask

  task automatic test_timeout();
    logic [55:0] prev;
    int fb, eb, gap;
    prev = o_Frame;
    fb = frame_q.size(); eb = err_cnt;
    send_byte(8'hC1, 1'b1); tick(10);
    send_byte(8'hC2, 1'b1); tick(10);
    send_byte(8'hC3, 1'b1);
    tick(1100);
    n_vec++; if (err_cnt - eb != 1) begin n_fail++; $display("[TB] FAIL timeout_err_count: got %0d expected 1", err_cnt - eb); end
    gap = last_err_cycle - dv_cyc_q[dv_cyc_q.size()-1];
    n_vec++; if (gap < 1023 || gap > 1025) begin n_fail++; $display("[TB] FAIL timeout_delay: got %0d expected 1023..1025", gap); end
    n_vec++; if (o_Frame !== prev || frame_q.size() != fb) begin n_fail++; $display("[TB] FAIL timeout_frame_kept: got %h expected %h", o_Frame, prev); end
    n_vec++; if (o_Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_busy: got %b expected 0", o_Busy); end
    send_frame(56'h41424344454647, 10);
    n_vec++; if (o_Frame !== 56'h41424344454647) begin n_fail++; $display("[TB] FAIL timeout_next_frame: got %h expected 41424344454647", o_Frame); end
  endtask

  // Start bit lands exactly on the expiry cycle: byte becomes byte 0.
  task automatic test_timeout_tie();
    int fb, eb;
    fb = frame_q.size(); eb = err_cnt;
    send_byte(8'hD1, 1'b1); tick(5);
    send_byte(8'hD2, 1'b1); tick(5);
    send_byte(8'hD3, 1'b1);
    tick(2 + TMO - 3);
    send_frame(56'h61626364656667, 0);
    tick(20);
    n_vec++; if (err_cnt - eb != 1) begin n_fail++; $display("[TB] FAIL tie_err_count: got %0d expected 1", err_cnt - eb); end
    n_vec++;
    if (frame_q.size() - fb != 1) begin
      n_fail++; $display("[TB] FAIL tie_frame_count: got %0d expected 1", frame_q.size() - fb);
    end else begin
      n_vec++; if (frame_q[fb] !== 56'h61626364656667) begin n_fail++; $display("[TB] FAIL tie_frame: got %h expected 61626364656667", frame_q[fb]); end
    end
  endtask

  task automatic test_framing_error();
    int rb, eb;
    rb = rx_q.size(); eb = err_cnt;
    send_byte(8'h21, 1'b1); tick(10);
    send_byte(8'h22, 1'b1); tick(10);
    send_byte(8'h23, 1'b0);
    tick(30);
    n_vec++; if (rx_q.size() - rb != 2) begin n_fail++; $display("[TB] FAIL ferr_dv_count: got %0d expected 2", rx_q.size() - rb); end
    n_vec++; if (err_cnt - eb != 1) begin n_fail++; $display("[TB] FAIL ferr_err_count: got %0d expected 1", err_cnt - eb); end
    n_vec++; if (o_Busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ferr_busy_low_line: got %b expected 1", o_Busy); end
    i_Rx_Serial = 1'b1;
    tick(10);
    n_vec++; if (o_Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ferr_busy_released: got %b expected 0", o_Busy); end
    send_frame(56'h31323334353637, 10);
    n_vec++; if (o_Frame !== 56'h31323334353637) begin n_fail++; $display("[TB] FAIL ferr_next_frame: got %h expected 31323334353637", o_Frame); end
    n_vec++; if (rx_q.size() - rb != 9 || err_cnt - eb != 1) begin n_fail++; $display("[TB] FAIL ferr_totals: got dv=%0d err=%0d expected 9 1", rx_q.size() - rb, err_cnt - eb); end
  endtask

  task automatic test_glitch();
    int rb, eb;
    rb = rx_q.size(); eb = err_cnt;
    i_Rx_Serial = 1'b0;
    tick(1);
    i_Rx_Serial = 1'b1;
    tick(20);
    n_vec++; if (rx_q.size() != rb || err_cnt != eb) begin n_fail++; $display("[TB] FAIL glitch_strobes: got dv=%0d err=%0d expected 0 0", rx_q.size() - rb, err_cnt - eb); end
    n_vec++; if (o_Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_busy: got %b expected 0", o_Busy); end
    send_frame(56'h55AA55AA55AA55, 4);
    tick(5);
    n_vec++;
    if (rx_q.size() - rb != NB) begin
      n_fail++; $display("[TB] FAIL order_dv_count: got %0d expected %0d", rx_q.size() - rb, NB);
    end else begin
      n_vec++; if (rx_q[rb] !== 8'h55 || rx_q[rb+1] !== 8'hAA) begin n_fail++; $display("[TB] FAIL order_bytes: got %h %h expected 55 aa", rx_q[rb], rx_q[rb+1]); end
    end
    n_vec++; if (o_Frame !== 56'h55AA55AA55AA55) begin n_fail++; $display("[TB] FAIL order_frame: got %h expected 55aa55aa55aa55", o_Frame); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b5;
    int rb, fb, eb;
    rb = rx_q.size(); fb = frame_q.size(); eb = err_cnt;
    send_byte(8'h71, 1'b1); tick(4);
    send_byte(8'h72, 1'b1); tick(4);
    send_byte(8'h73, 1'b1); tick(4);
    send_byte(8'h74, 1'b1); tick(4);
    b5 = 8'h75;
    i_Rx_Serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      i_Rx_Serial = b5[i];
      tick(CPB);
    end
    i_Rx_Serial = b5[4];
    tick(1);
    i_Reset = 1'b1;
    #1;
    n_vec++; if (o_Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", o_Busy); end
    n_vec++; if (o_Frame !== 56'h0 || o_Rx_Byte !== 8'h00) begin n_fail++; $display("[TB] FAIL midrst_data: got frame=%h byte=%h expected 0 0", o_Frame, o_Rx_Byte); end
    n_vec++; if (o_Rx_DV !== 1'b0 || o_Frame_Valid !== 1'b0 || o_Frame_Err !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_strobes: got %b%b%b expected 000", o_Rx_DV, o_Frame_Valid, o_Frame_Err); end
    tick(1);
    i_Reset = 1'b0;
    i_Rx_Serial = 1'b1;
    tick(30);
    n_vec++; if (rx_q.size() - rb != 4 || frame_q.size() != fb || err_cnt != eb) begin n_fail++; $display("[TB] FAIL midrst_no_strobe: got dv=%0d fv=%0d err=%0d expected 4 0 0", rx_q.size() - rb, frame_q.size() - fb, err_cnt - eb); end
    send_frame(56'h81828384858687, 4);
    n_vec++; if (o_Frame !== 56'h81828384858687) begin n_fail++; $display("[TB] FAIL midrst_next_frame: got %h expected 81828384858687", o_Frame); end
  endtask

  initial begin
    i_Reset = 1'b1;
    i_Rx_Serial = 1'b1;
    test_reset();
    test_nominal();
    tick(20);
    test_back_to_back();
    tick(20);
    test_timeout();
    tick(20);
    test_timeout_tie();
    tick(20);
    test_framing_error();
    tick(20);
    test_glitch();
    tick(20);
    test_reset_mid_frame();
    tick(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- UART receiver and frame assembler; the receiving end of the host-to-FPGA command link driven by uart_tx.
- Samples the serial line (8N1, LSB first) and assembles FRAME_BYTES consecutive bytes into one command frame.
- Presents the frame to the renderer control logic with a single-cycle valid strobe.
- Sits directly behind the top-level RX pin (PIN_13).

Parameters:
- CLKS_PER_BIT, 2, clocks per UART bit. Same value as uart_tx / top UART_DIV. Legal minimum is 2.
- FRAME_BYTES, 7, bytes per command frame. Byte 0 is the opcode; the remaining bytes are the payload.
- TIMEOUT_CLKS, 1024, idle clocks after a stop bit before a partial frame is discarded.

Ports:
- i_Clock  input  1  system clock
- i_Reset  input  1  asynchronous, active-high reset
- i_Rx_Serial  input  1  raw asynchronous UART line, idle high
- o_Rx_DV  output  1  one-cycle strobe: o_Rx_Byte is a valid received byte
- o_Rx_Byte  output  8  last received byte
- o_Frame_Valid  output  1  one-cycle strobe: o_Frame is complete
- o_Frame  output  8*FRAME_BYTES  assembled frame; byte 0 in bits [8*FRAME_BYTES-1 -: 8], last byte in [7:0]
- o_Frame_Err  output  1  one-cycle strobe: partial frame discarded (framing error or timeout)
- o_Busy  output  1  high while a byte is being received or a frame is partially assembled

Behaviour:
- Reset (async assert, synchronous release):
  - All strobes 0; o_Rx_Byte = 0; o_Frame = 0; o_Busy = 0.
  - Byte index = 0; timeout counter = 0; state = IDLE.
  - Synchronizer flops preset to 1 (idle line).
  - Reset asserted mid-byte or mid-frame abandons all progress; no strobe is issued.
- Input sync: i_Rx_Serial passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s, which adds 2 cycles of latency.
- Bit FSM states:
  - IDLE: wait for rx_s == 0, then go to START with bit counter = 0.
  - START: count CLKS_PER_BIT/2 (integer division) clocks, then sample. If rx_s == 1, this is a glitch: return to IDLE with no strobe. If rx_s == 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT clocks. 8 samples are shifted in LSB first, then go to STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - rx_s == 1: the byte is good. In the same cycle, o_Rx_DV = 1 and o_Rx_Byte updates; then go to IDLE.
    - rx_s == 0: framing error. No o_Rx_DV. o_Frame_Err = 1 if byte index != 0, or if FRAME_BYTES == 1. Byte index clears. Go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s == 1, then go to IDLE. This prevents a stuck-low line from re-triggering.
- Frame assembly:
  - Each good byte is written into the slot for the current byte index, and the index increments.
  - When the byte at index FRAME_BYTES-1 arrives: o_Frame updates with all bytes and o_Frame_Valid pulses in the same cycle as o_Rx_DV. The index wraps to 0.
  - o_Frame holds its value until the next complete frame; a partial frame never modifies o_Frame.
- Timeout:
  - Counts only while the index != 0 and the FSM is in IDLE.
  - Clears on any start-bit detection.
  - On reaching TIMEOUT_CLKS: index = 0 and o_Frame_Err pulses once.
- o_Busy = (state != IDLE) || (index != 0).
- A start bit detected in the same cycle the timeout expires: the timeout wins. The frame is discarded, and the new byte becomes byte 0 of a new frame.
- Latency: o_Rx_DV occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 (±1) clocks after the falling edge of the start bit on i_Rx_Serial.

Test Plan:
- Nominal frame: uart_tx (CLKS_PER_BIT=2) sends 0x01, 0x00 ×5, 0x10, each followed by a 40-clock gap. Expect 7 o_Rx_DV pulses with the matching bytes, then one o_Frame_Valid with o_Frame = 56'h01000000000010 and no o_Frame_Err.
- Back-to-back frames: two frames, 0xA5..0xAB then 0x11..0x17, with no inter-byte gap. Expect two o_Frame_Valid pulses, and o_Frame = 56'hA5A6A7A8A9AAAB, then 56'h11121314151617.
- Timeout: send 3 bytes, then idle for 1100 clocks. Expect one o_Frame_Err about 1024 clocks after the last stop bit, and o_Frame unchanged. A following 7-byte frame is then received correctly.
- Framing error: send byte 2 of a frame with the stop bit forced low and the line held low for 30 clocks. Expect no o_Rx_DV for that byte, one o_Frame_Err, and no activity until the line returns high. The next full frame is accepted.
- Glitch rejection: a 1-clock low pulse on an idle line produces no o_Rx_DV and o_Busy returns to 0. Also send a payload of 0x55 and 0xAA bytes to check bit ordering.
- Reset mid-frame: assert i_Reset for 1 clock during bit 4 of byte 5. Expect all outputs 0 immediately, no strobes, and a subsequent complete frame decoded correctly.
